rr_arb4_ctrl: RTL
=================

# rr_arb4_ctrl

- Round-robin arbiter and sequencer that shares one downstream resource among four requesters.
- Each cycle's request vector feeds a circular priority scan. The scan starts at a rotating pointer, so no requester starves.
- The winner holds a registered one-hot grant plus an encoded index until it releases its request or exceeds a hold limit.
- It sits between the 4-bit request lines and the shared datapath. `gnt_id` directly drives the datapath's select.

## Interface
- `MAX_HOLD`, default 8: maximum consecutive grant cycles per tenure. 0 disables preemption. Legal range 0..2^CNT_W-1.
- `CNT_W`, default 8: width of the hold counter.
- `clk`  in  1: rising-edge clock.
- `rst_n`  in  1: asynchronous, active-low reset.
- `req`  in  4: request lines. Bit k is held high while requester k wants or uses the resource.
- `gnt`  out  4: registered one-hot grant; all-zero when no grant.
- `gnt_id`  out  2: encoded index of the current or last grantee.
- `gnt_vld`  out  1: high exactly when `gnt` is nonzero.
- `preempt`  out  1: one-cycle pulse marking a forced release caused by the hold limit.

## Operation
- States: IDLE, GRANT, GAP. State `ptr[1:0]` (next-highest-priority index) and `cnt[CNT_W-1:0]` are internal.
- Arbitration function: scan `req` in order `ptr`, `ptr+1`, `ptr+2`, `ptr+3` (mod 4). The first set bit wins.
- IDLE:
  - If `|req`, register the winner: `gnt` becomes one-hot(win), `gnt_id` becomes win, `gnt_vld` becomes 1, `cnt` becomes 1, and the state moves to GRANT.
  - Otherwise stay in IDLE.
- GRANT, evaluated each edge with `id` = `gnt_id`:
  - `req[id]`=0: release. `gnt` becomes 0, `gnt_vld` becomes 0, `ptr` becomes id+1, the state moves to GAP, and `preempt` stays 0.
  - Else if MAX_HOLD≠0 and `cnt`==MAX_HOLD: preempt. Same updates as release, plus `preempt` becomes 1.
  - Else `cnt` increments and the grant holds.
  - Release has priority over preempt when both conditions hit on the same edge.
- GAP, a mandatory single dead cycle:
  - `preempt` returns to 0.
  - Arbitrate using the updated `ptr`. If there is a winner, move to GRANT exactly as from IDLE; otherwise move to IDLE.
  - A preempted requester still holding `req` is lowest priority. If it is the only requester, it is re-granted after the gap.
- Changes on non-granted `req` bits during GRANT have no effect until the next arbitration.
- `gnt_id` retains its last value when `gnt_vld`=0.
- `cnt` saturates logic: it never increments past MAX_HOLD. With MAX_HOLD=0 it wraps freely and is ignored.

## Timing
- Reset (async assert, any time, including mid-grant):
  - Outputs clear immediately without a clock: `gnt`=0000, `gnt_id`=00, `gnt_vld`=0, `preempt`=0.
  - Internal state goes to IDLE with `ptr`=0 and `cnt`=0.
  - Deassertion is synchronised externally. The first arbitration happens on the first edge after `rst_n` is high.
- Request-to-grant latency: 1 edge from IDLE. A `req` sampled high at edge N gives `gnt` valid after edge N.
- Release-to-regrant: 2 edges. Edge N drops `gnt` (GAP); edge N+1 issues the next grant.
- Grant duration under a held request is exactly MAX_HOLD cycles. `preempt` is high during the GAP cycle that follows.
- All outputs are registered; there is no combinational path from `req` to any output.

## Test plan
- Reset: drive `rst_n`=0 mid-grant with `gnt`=0100. Outputs must go to `gnt`=0000, `gnt_id`=0, `gnt_vld`=0, `preempt`=0 before the next edge. After release, `req`=1000 yields `gnt`=1000.
- Rotation: hold `req`=1111 and have each grantee drop its bit 2 cycles after being granted, then reassert it. The grant order must be 0,1,2,3,0 with exactly one `gnt_vld`=0 cycle between tenures.
- Pointer: grant 2, release it, then present `req`=0101. The next grant must be `gnt`=0001 (scan order 3,0), not 0100.
- Preempt: with MAX_HOLD=8, hold `req`=0001 for 20 cycles.
  - Expect `gnt` high 8 cycles, then 1 dead cycle with `preempt`=1, then `gnt`=0001 again.
  - Adding `req[1]`=1 during the first tenure must make `gnt`=0010 follow the gap instead.
- Release/preempt collision: drop `req[0]` on the same edge that `cnt`==MAX_HOLD. Expect `gnt`=0000 and `preempt`=0.
- Disabled limit: with MAX_HOLD=0 and `req`=0010 held for 300 cycles, `gnt`=0010 must stay continuous and `preempt` must never assert.

Source files
------------

// File: rtl/rr_arb4_ctrl.sv
// Four-way round-robin arbiter with hold-limit preemption and a mandatory
// one-cycle gap between tenures. All outputs are registered.
module rr_arb4_ctrl #(
    parameter int unsigned MAX_HOLD = 8,
    parameter int unsigned CNT_W    = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    output logic [3:0] gnt,
    output logic [1:0] gnt_id,
    output logic       gnt_vld,
    output logic       preempt
);

    localparam int unsigned       NUM_REQ  = 4;
    localparam int unsigned       ID_W     = 2;
    localparam logic [CNT_W-1:0]  HOLD_LIM = CNT_W'(MAX_HOLD);
    localparam logic              LIM_EN   = (MAX_HOLD != 0);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [ID_W-1:0]    ptr_q, ptr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [3:0]         gnt_d;
    logic [ID_W-1:0]    gnt_id_d;
    logic               gnt_vld_d;
    logic               preempt_d;

    logic               win_vld;
    logic [ID_W-1:0]    win_id;
    logic [ID_W-1:0]    scan_idx;
    logic               hold_hit;

    // Circular priority scan starting at ptr; lowest offset is assigned last and wins.
    always_comb begin
        win_vld  = 1'b0;
        win_id   = ptr_q;
        scan_idx = ptr_q;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            scan_idx = ptr_q + ID_W'(i);
            if (req[scan_idx]) begin
                win_vld = 1'b1;
                win_id  = scan_idx;
            end
        end
    end

    assign hold_hit = LIM_EN && (cnt_q == HOLD_LIM);

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            cnt_q   <= '0;
            gnt     <= '0;
            gnt_id  <= '0;
            gnt_vld <= 1'b0;
            preempt <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            gnt     <= gnt_d;
            gnt_id  <= gnt_id_d;
            gnt_vld <= gnt_vld_d;
            preempt <= preempt_d;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        gnt_d     = gnt;
        gnt_id_d  = gnt_id;
        gnt_vld_d = gnt_vld;
        preempt_d = 1'b0;

        unique case (state_q)
            IDLE, GAP: begin
                if (win_vld) begin
                    state_d   = GRANT;
                    gnt_d     = 4'b0001 << win_id;
                    gnt_id_d  = win_id;
                    gnt_vld_d = 1'b1;
                    cnt_d     = CNT_W'(1);
                end else begin
                    state_d   = IDLE;
                    gnt_d     = '0;
                    gnt_vld_d = 1'b0;
                end
            end
            GRANT: begin
                // Release wins over preemption; both end the tenure the same way.
                if (!req[gnt_id] || hold_hit) begin
                    state_d   = GAP;
                    gnt_d     = '0;
                    gnt_vld_d = 1'b0;
                    ptr_d     = gnt_id + ID_W'(1);
                    preempt_d = req[gnt_id];
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d   = IDLE;
                gnt_d     = '0;
                gnt_vld_d = 1'b0;
            end
        endcase
    end

endmodule
